// File: rtl/idivn_pkg.sv
// rtl/idivn_pkg.sv - shared types and derivation helpers for the iterative mantissa divider
package idivn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_NORM = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam state_t RST_STATE      = ST_IDLE;
   localparam logic   RST_ZERO_RESID = 1'b0;
   localparam logic   RST_OVERFLOW   = 1'b0;

   // Iterations needed to resolve all 2*WIDTH-1 quotient bits at rbits per cycle
   function automatic int calc_n(input int width, input int rbits);
      return (2 * width - 1 + rbits - 1) / rbits;
   endfunction

   // Bits needed to hold a shift count of 0..2*WIDTH-1
   function automatic int calc_lsw(input int width);
      int v;
      v = 0;
      while ((1 << v) < 2 * width) v++;
      return v;
   endfunction

endpackage

// File: rtl/idivn_step.sv
// rtl/idivn_step.sv - one combinational restoring division step (one quotient bit)
module idivn_step #(
   parameter int WIDTH = 53
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH:0]   o_rem,
   output logic             o_q
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_diff;

   // Extra top bit turns the subtraction borrow into the compare result
   assign w_shift = {i_rem, i_bit};
   assign w_diff  = w_shift - {2'b00, i_divisor};
   assign o_q     = ~w_diff[WIDTH+1];
   assign o_rem   = o_q ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/idivn_iter.sv
// rtl/idivn_iter.sv - iterative radix-2^RBITS unsigned divider, Q = floor((A << (WIDTH-1)) / B)
module idivn_iter
   import idivn_pkg::*;
#(
   parameter int WIDTH = 53,
   parameter int RBITS = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [WIDTH-1:0]              i_divident,
   input  logic [WIDTH-1:0]              i_divisor,
   input  logic                          i_abort,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [2*WIDTH-2:0]            o_result,
   output logic [calc_lsw(WIDTH)-1:0]    o_lshift,
   output logic                          o_zero_resid,
   output logic                          o_overflow
);

   localparam int QBITS = 2 * WIDTH - 1;
   localparam int N     = calc_n(WIDTH, RBITS);
   localparam int LSW   = calc_lsw(WIDTH);
   localparam int DBITS = N * RBITS;
   localparam int CW    = (N > 1) ? $clog2(N) : 1;

   typedef struct packed {
      state_t             state;
      logic [DBITS-1:0]   dvd;
      logic [QBITS-1:0]   quo;
      logic [WIDTH:0]     rem;
      logic [WIDTH-1:0]   dvs;
      logic [CW-1:0]      cnt;
      logic [QBITS-1:0]   result;
      logic [LSW-1:0]     lshift;
      logic               zero_resid;
      logic               overflow;
   } regs_t;

   regs_t r, rin;

   logic [WIDTH:0]   w_rem [0:RBITS];
   logic [RBITS-1:0] w_qbits;
   logic [LSW-1:0]   w_lz;

   // Step 0 consumes the dividend MSB, so its quotient bit is the most significant of the group
   assign w_rem[0] = r.rem;
   for (genvar gi = 0; gi < RBITS; gi++) begin : g_step
      idivn_step #(.WIDTH(WIDTH)) u_step (
         .i_rem     (w_rem[gi]),
         .i_bit     (r.dvd[DBITS-1-gi]),
         .i_divisor (r.dvs),
         .o_rem     (w_rem[gi+1]),
         .o_q       (w_qbits[RBITS-1-gi])
      );
   end

   always_comb begin
      w_lz = LSW'(QBITS);
      for (int i = 0; i < QBITS; i++) begin
         if (r.quo[i]) w_lz = LSW'(QBITS - 1 - i);
      end
   end

   always_comb begin
      rin = r;
      case (r.state)
         ST_IDLE: begin
            if (i_valid) begin
               rin.dvs = i_divisor;
               rin.dvd = DBITS'({i_divident, {(WIDTH-1){1'b0}}});
               rin.rem = '0;
               rin.quo = '0;
               rin.cnt = '0;
               if (i_divisor == '0) begin
                  rin.state      = ST_DONE;
                  rin.result     = '1;
                  rin.lshift     = '0;
                  rin.zero_resid = 1'b0;
                  rin.overflow   = 1'b1;
               end else begin
                  rin.state = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (i_abort) begin
               rin.state = ST_IDLE;
            end else begin
               rin.dvd = {r.dvd[DBITS-RBITS-1:0], {RBITS{1'b0}}};
               rin.quo = {r.quo[QBITS-RBITS-1:0], w_qbits};
               rin.rem = w_rem[RBITS];
               rin.cnt = r.cnt + CW'(1);
               if (r.cnt == CW'(N - 1)) rin.state = ST_NORM;
            end
         end
         ST_NORM: begin
            if (i_abort) begin
               rin.state = ST_IDLE;
            end else begin
               rin.result     = r.quo;
               rin.lshift     = w_lz;
               rin.zero_resid = (r.rem == '0);
               rin.overflow   = 1'b0;
               rin.state      = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_ready) rin.state = ST_IDLE;
         end
         default: rin.state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r            <= '0;
         r.state      <= RST_STATE;
         r.zero_resid <= RST_ZERO_RESID;
         r.overflow   <= RST_OVERFLOW;
      end else begin
         r <= rin;
      end
   end

   assign o_ready      = (r.state == ST_IDLE);
   assign o_valid      = (r.state == ST_DONE);
   assign o_result     = r.result;
   assign o_lshift     = r.lshift;
   assign o_zero_resid = r.zero_resid;
   assign o_overflow   = r.overflow;

endmodule

// File: tb/tb_idivn_iter.sv
// tb/tb_idivn_iter.sv - scoreboard bench for idivn_iter at (53,2), (8,1) and (8,3)
module tb_idivn_iter;

   logic        clk = 1'b0;
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          done_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] q;
      int           ls;
      bit           zr;
      bit           ov;
      int           acc;
      int           lat;
   } exp_t;

   // Reference: plain wide arithmetic on the defining formula
   function automatic exp_t model(input int w, input int rb, input logic [127:0] av, input logic [127:0] bv);
      exp_t         e;
      logic [127:0] num;
      logic [127:0] q;
      int           qb;
      int           len;
      qb    = 2 * w - 1;
      e.acc = 0;
      if (bv == 0) begin
         e.q   = (128'(1) << qb) - 128'(1);
         e.ls  = 0;
         e.zr  = 1'b0;
         e.ov  = 1'b1;
         e.lat = 1;
      end else begin
         num = av << (w - 1);
         q   = num / bv;
         len = 0;
         while ((q >> len) != 0) len++;
         e.q   = q;
         e.ls  = qb - len;
         e.zr  = ((num % bv) == 0);
         e.ov  = 1'b0;
         e.lat = (qb + rb - 1) / rb + 2;
      end
      return e;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int W   = (g == 0) ? 53 : 8;
      localparam int R   = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
      localparam int QB  = 2 * W - 1;
      localparam int N   = (QB + R - 1) / R;
      localparam int LSW = $clog2(QB + 1);
      localparam int KAB = (N > 21) ? 20 : N - 2;

      logic           rst = 1'b1;
      logic           valid = 1'b0;
      logic           ready_o;
      logic [W-1:0]   a = '0;
      logic [W-1:0]   b = '0;
      logic           abort = 1'b0;
      logic           valid_o;
      logic           ready_i = 1'b0;
      logic [QB-1:0]  result;
      logic [LSW-1:0] lshift;
      logic           zr;
      logic           ov;
      bit             hold = 1'b0;
      bit             seen = 1'b0;
      exp_t           sbq[$];
      exp_t           m_e;

      idivn_iter #(.WIDTH(W), .RBITS(R)) u_dut (
         .i_clk        (clk),
         .i_rst        (rst),
         .i_valid      (valid),
         .o_ready      (ready_o),
         .i_divident   (a),
         .i_divisor    (b),
         .i_abort      (abort),
         .o_valid      (valid_o),
         .i_ready      (ready_i),
         .o_result     (result),
         .o_lshift     (lshift),
         .o_zero_resid (zr),
         .o_overflow   (ov)
      );

      task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
         n_tests++;
         if (got !== expv) begin
            n_fail++;
            $display("FAIL cfg%0d %s got=%0h exp=%0h", g, name, got, expv);
         end
      endtask

      task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input bit push);
         exp_t e;
         int   t;
         e = model(W, R, 128'(av), 128'(bv));
         @(posedge clk); #1;
         a = av;
         b = bv;
         valid = 1'b1;
         t = 0;
         @(negedge clk);
         while (!ready_o && t < 4 * N + 200) begin
            t++;
            @(negedge clk);
         end
         if (!ready_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL cfg%0d accept_timeout got=o_ready0 exp=o_ready1", g);
            @(posedge clk); #1;
            valid = 1'b0;
            return;
         end
         e.acc = int'(cyc) + 1;
         if (push) sbq.push_back(e);
         @(posedge clk); #1;
         valid = 1'b0;
      endtask

      task automatic drain();
         int t;
         t = 0;
         while ((sbq.size() != 0 || !ready_o) && t < 4 * N + 200) begin
            t++;
            @(negedge clk);
         end
         chk("drain_empty", 128'(sbq.size()), 128'(0));
      endtask

      task automatic chk_reset_vals(input string tag);
         chk({tag, "_ready"},  128'(ready_o), 128'(1));
         chk({tag, "_valid"},  128'(valid_o), 128'(0));
         chk({tag, "_result"}, 128'(result),  128'(0));
         chk({tag, "_lshift"}, 128'(lshift),  128'(0));
         chk({tag, "_zr"},     128'(zr),      128'(0));
         chk({tag, "_ov"},     128'(ov),      128'(0));
      endtask

      initial begin
         forever begin
            @(posedge clk); #1;
            ready_i = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
         end
      end

      // Monitor: every DONE cycle is compared with the scoreboard head, so stalls check stability
      always @(negedge clk) begin
         if (valid_o) begin
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL cfg%0d unexpected_valid got=1 exp=0", g);
            end else begin
               m_e = sbq[0];
               if (!seen) begin
                  seen = 1'b1;
                  chk("latency", 128'(int'(cyc) - m_e.acc + 1), 128'(m_e.lat));
               end
               chk("result",     128'(result), m_e.q);
               chk("lshift",     128'(lshift), 128'(m_e.ls));
               chk("zero_resid", 128'(zr),     128'(m_e.zr));
               chk("overflow",   128'(ov),     128'(m_e.ov));
               if (ready_i) begin
                  void'(sbq.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end

      initial begin
         logic [W-1:0] ra;
         logic [W-1:0] rbv;
         int           t;
         repeat (2) @(posedge clk);
         #1;
         chk_reset_vals("reset");
         rst = 1'b0;

         send(W'(1) << (W - 1), W'(1) << (W - 1), 1'b1);
         send('1, W'(1) << (W - 1), 1'b1);
         send(W'(1), W'(3), 1'b1);
         send(W'(5), W'(0), 1'b1);
         send(W'(200), W'(7), 1'b1);
         send(W'(0), W'(9), 1'b1);
         send('1, W'(1), 1'b1);
         drain();

         // Stall with busy-time i_valid noise that must be ignored
         hold = 1'b1;
         send(W'(200), W'(7), 1'b1);
         a = W'(77);
         b = W'(3);
         valid = 1'b1;
         t = 0;
         @(negedge clk);
         while (!valid_o && t < N + 10) begin
            t++;
            @(negedge clk);
         end
         chk("stall_reach_done", 128'(valid_o), 128'(1));
         repeat (10) @(posedge clk);
         #1;
         valid = 1'b0;
         @(posedge clk); #1;
         hold = 1'b0;
         drain();

         send(W'(1) << (W - 2), W'(5), 1'b0);
         repeat (KAB) @(posedge clk);
         #1;
         abort = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0;
         @(negedge clk);
         chk("abort_ready", 128'(ready_o), 128'(1));
         chk("abort_valid", 128'(valid_o), 128'(0));
         repeat (N + 5) @(posedge clk);

         for (int i = 0; i < 30; i++) begin
            ra  = W'({$urandom(), $urandom()});
            rbv = (i % 6 == 0) ? W'($urandom_range(0, 3)) : W'({$urandom(), $urandom()});
            if (i % 7 == 3) rbv = rbv >> $urandom_range(0, W - 1);
            send(ra, rbv, 1'b1);
         end
         drain();

         send(W'(123), W'(45), 1'b0);
         repeat (3) @(posedge clk);
         #1;
         rst = 1'b1;
         @(posedge clk); #1;
         chk_reset_vals("midbusy_rst");
         rst = 1'b0;
         send(W'(200), W'(7), 1'b1);
         drain();

         done_cnt++;
      end
   end

   initial begin
      while (done_cnt < 3 && cyc < 90000) @(posedge clk);
      if (done_cnt < 3) begin
         n_tests++;
         n_fail++;
         $display("FAIL global_timeout got=%0d exp=3", done_cnt);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
